// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit path.
//   tx_state_t         : frame sequencer states
//   UART_DEF_DATA_BITS : default payload width per frame
//   UART_DEF_STOP_BITS : default stop-bit count per frame
//   UART_IDLE          : line level while no frame is being sent
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam int   UART_DEF_DATA_BITS = 8;
  localparam int   UART_DEF_STOP_BITS = 1;
  localparam logic UART_IDLE          = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serialises one DATA_BITS-wide word per frame onto the TX line, LSB first,
// framed as start / data / [parity] / STOP_BITS stop bits. Bit timing comes
// from baud_tick, a one-cycle enable produced by the baud divider; it is never
// used as a clock.
//
// Optional feature (build macro UART_TX_PARITY_EN):
//   defined   -> parameter PARITY_ODD is added and a parity bit follows DATA
//   undefined -> no parity state, no parity logic
//
// Ports:
//   clk_in    in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   baud_tick in   one-cycle pulse per bit period
//   tx_data   in   word to send, sampled only on accept
//   tx_valid  in   upstream has a word
//   tx_ready  out  block can accept a word (registered, high only in IDLE)
//   tx        out  serial line, idle high (registered)
//   tx_busy   out  a frame is in progress
//   tx_done   out  one-cycle pulse at the end of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DEF_DATA_BITS,
  parameter int STOP_BITS = UART_DEF_STOP_BITS
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int              CW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CW-1:0]        bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= UART_IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= UART_IDLE;
          if (tx_valid && ready_q) begin
            shift_q    <= tx_data;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ALIGN;
`ifdef UART_TX_PARITY_EN
            // Taken from the accepted word so shifting cannot disturb it.
            parity_q   <= (^tx_data) ^ PARITY_ODD;
`endif
          end else begin
            // ready stays low during the tx_done cycle, so the two never
            // overlap; it rises one cycle after the frame ends.
            ready_q <= 1'b1;
          end
        end

        // Holding the line high until the next tick keeps the start bit a
        // full bit period wide regardless of where accept fell in the period.
        ALIGN: begin
          if (baud_tick) begin
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end

        START: begin
          if (baud_tick) begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end

        DATA: begin
          if (baud_tick) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= STOP;
`endif
            end else begin
              // shift_q[1] is the bit that becomes shift_q[0] after this tick.
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= STOP;
          end
        end
`endif

        STOP: begin
          if (baud_tick) begin
            if (stop_cnt_q == LAST_STOP) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          tx_q    <= UART_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx. baud_tick pulses every 4 clocks. Instance a uses
// default parameters, instance b has STOP_BITS=2, and with UART_TX_PARITY_EN
// defined instance c has PARITY_ODD=1. sel chooses which instance the shared
// driver variables feed and which one the monitor signals observe.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic [7:0] data_v = 8'h00;
  logic       valid_v = 1'b0;
  int         sel = 0;
  int         tick_cnt = 0;
  int         done_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  logic valid_a, ready_a, tx_a, busy_a, done_a;
  logic valid_b, ready_b, tx_b, busy_b, done_b;
  logic valid_c, ready_c, tx_c, busy_c, done_c;
  logic mon_tx, mon_ready, mon_busy, mon_done;

  always #5 clk = ~clk;

  // Tick every 4 cycles, changed on the falling edge so it is stable at posedge.
  always @(negedge clk) begin
    tick_cnt  = (tick_cnt + 1) % 4;
    baud_tick = (tick_cnt == 0);
  end

  always @(negedge clk) if (done_a) done_cnt++;

  assign valid_a = valid_v && (sel == 0);
  assign valid_b = valid_v && (sel == 1);
  assign valid_c = valid_v && (sel == 2);

  uart_tx dut_a (
    .clk_in(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_v),
    .tx_valid(valid_a), .tx_ready(ready_a), .tx(tx_a), .tx_busy(busy_a),
    .tx_done(done_a)
  );

  uart_tx #(.STOP_BITS(2)) dut_b (
    .clk_in(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_v),
    .tx_valid(valid_b), .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b),
    .tx_done(done_b)
  );

`ifdef UART_TX_PARITY_EN
  uart_tx #(.PARITY_ODD(1'b1)) dut_c (
    .clk_in(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_v),
    .tx_valid(valid_c), .tx_ready(ready_c), .tx(tx_c), .tx_busy(busy_c),
    .tx_done(done_c)
  );
`else
  assign ready_c = 1'b0;
  assign tx_c    = 1'b1;
  assign busy_c  = 1'b0;
  assign done_c  = 1'b0;
`endif

  always_comb begin
    mon_tx = tx_a; mon_ready = ready_a; mon_busy = busy_a; mon_done = done_a;
    if (sel == 1) begin
      mon_tx = tx_b; mon_ready = ready_b; mon_busy = busy_b; mon_done = done_b;
    end else if (sel == 2) begin
      mon_tx = tx_c; mon_ready = ready_c; mon_busy = busy_c; mon_done = done_c;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a word when the selected instance is ready; verify ready drops
  // the cycle after accept. hold keeps tx_valid asserted afterwards.
  task automatic send(input logic [7:0] b, input bit hold, input string tag);
    int w;
    w = 0;
    while (!mon_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready_wait"}, 32'(mon_ready), 32'd1);
    data_v  = b;
    valid_v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    $display("send %s: data=%02h", tag, b);
    check({tag, "_ready_drop"}, 32'(mon_ready), 32'd0);
    check({tag, "_busy_set"}, 32'(mon_busy), 32'd1);
    check({tag, "_tx_idle_align"}, 32'(mon_tx), 32'd1);
    if (!hold) valid_v = 1'b0;
  endtask

  // Find the start bit, then check every cycle of every bit (4 cycles each),
  // then the tx_done pulse and the return of tx_ready. idle returns how many
  // high samples preceded the start bit.
  task automatic frame_check(input logic [7:0] b, input int nstop, input string tag,
                             output int idle);
    logic exp_bits [0:15];
    int   n;
    bit   found;
    n = 0;
    exp_bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin exp_bits[n] = b[i]; n++; end
`ifdef UART_TX_PARITY_EN
    exp_bits[n] = (^b) ^ (sel == 2); n++;
`endif
    for (int i = 0; i < nstop; i++) begin exp_bits[n] = 1'b1; n++; end
    idle  = 0;
    found = 1'b0;
    while (!found && idle < 64) begin
      if (mon_tx == 1'b0) found = 1'b1;
      else begin idle++; @(negedge clk); end
    end
    check({tag, "_start_seen"}, 32'(found), 32'd1);
    if (!found) return;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        check($sformatf("%s_bit%0d_c%0d", tag, i, c), 32'(mon_tx), 32'(exp_bits[i]));
      end
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(mon_done), 32'd1);
    check({tag, "_ready_low_at_done"}, 32'(mon_ready), 32'd0);
    check({tag, "_busy_clear"}, 32'(mon_busy), 32'd0);
    check({tag, "_tx_high_at_done"}, 32'(mon_tx), 32'd1);
    @(negedge clk);
    check({tag, "_done_single"}, 32'(mon_done), 32'd0);
    check({tag, "_ready_back"}, 32'(mon_ready), 32'd1);
    $display("frame %s: data=%02h bits=%0d checked", tag, b, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle, idle2, base, w;
    bit ok;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_b_ready", 32'(ready_b), 32'd1);

    // 0xA5 single frame
    sel = 0;
    base = done_cnt;
    send(8'hA5, 1'b0, "a5");
    frame_check(8'hA5, 1, "a5", idle);
    check("a5_done_count", 32'(done_cnt - base), 32'd1);

    // 0x00 then 0xFF with tx_valid held high
    base = done_cnt;
    send(8'h00, 1'b1, "b2b0");
    data_v = 8'hFF;
    idle2 = 0;
    fork
      begin
        frame_check(8'h00, 1, "b2b0", idle);
        frame_check(8'hFF, 1, "b2b1", idle2);
      end
      begin
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
          @(negedge clk);
          if (mon_ready) begin
            @(posedge clk);
            @(negedge clk);
            valid_v = 1'b0;
            ok = 1'b1;
          end
        end
        check("b2b_second_accept", 32'(ok), 32'd1);
      end
    join
    check("b2b_gap_le4", 32'((idle2 + 1) <= 4), 32'd1);
    check("b2b_done_count", 32'(done_cnt - base), 32'd2);

    // reset during data bit 3 of 0x3C, then 0x81
    base = done_cnt;
    send(8'h3C, 1'b0, "rst3c");
    w = 0;
    while (tx_a != 1'b0 && w < 64) begin @(negedge clk); w++; end
    check("rst3c_start_seen", 32'(tx_a), 32'd0);
    repeat (4 * 4 + 1) @(negedge clk);
    check("rst3c_bit3", 32'(tx_a), 32'd1);
    check("rst3c_busy_mid", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset asserted mid-frame");
    check("rst3c_tx", 32'(tx_a), 32'd1);
    check("rst3c_ready", 32'(ready_a), 32'd1);
    check("rst3c_busy", 32'(busy_a), 32'd0);
    check("rst3c_no_done", 32'(done_cnt - base), 32'd0);
    send(8'h81, 1'b0, "x81");
    frame_check(8'h81, 1, "x81", idle);

    // tx_data changed and tx_valid raised while busy: 0x12 must still go out
    data_v = 8'h12;
    send(8'h12, 1'b0, "x12");
    fork
      frame_check(8'h12, 1, "x12", idle);
      begin
        repeat (8) @(negedge clk);
        data_v  = 8'hEE;
        valid_v = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
          @(negedge clk);
          if (mon_ready) begin
            @(posedge clk);
            @(negedge clk);
            valid_v = 1'b0;
            ok = 1'b1;
          end
        end
        check("xee_accept_after", 32'(ok), 32'd1);
      end
    join
    frame_check(8'hEE, 1, "xee", idle);

    // two stop bits
    sel = 1;
    @(negedge clk);
    send(8'h55, 1'b0, "s2_55");
    frame_check(8'h55, 2, "s2_55", idle);

`ifdef UART_TX_PARITY_EN
    sel = 0;
    @(negedge clk);
    send(8'h07, 1'b0, "par07");
    frame_check(8'h07, 1, "par07", idle);
    sel = 2;
    @(negedge clk);
    send(8'h03, 1'b0, "par03odd");
    frame_check(8'h03, 1, "par03odd", idle);
`endif

    sel = 0;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
